// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes and FSM state encoding shared by the sequential ALU
package alu_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
   localparam logic [3:0] ALU_MULT = 4'b1000;
   localparam logic [3:0] ALU_DIVU = 4'b1001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - one-bit-per-cycle shift-add multiplier / restoring divider
module alu_muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             last,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   // hi/lo hold {partial product, remaining multiplier} or {remainder, dividend/quotient}
   logic             run_q, run_d;
   logic             div_q, div_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] b_q, b_d;

   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] trial;
   logic             fits;

   // Load on start, then one multiplier/quotient bit per cycle; last flags the final iteration
   always_comb begin
      run_d   = run_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      b_d     = b_q;
      last    = 1'b0;
      add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
      shifted = {hi_q, lo_q[WIDTH-1]};
      fits    = (shifted >= {1'b0, b_q});
      // when the divisor fits, the difference is below b_q so WIDTH bits suffice
      trial   = shifted[WIDTH-1:0] - b_q;
      if (start) begin
         run_d = 1'b1;
         div_d = is_div;
         cnt_d = '0;
         hi_d  = '0;
         lo_d  = is_div ? op_a : op_b;
         b_d   = is_div ? op_b : op_a;
      end else if (run_q) begin
         if (div_q) begin
            hi_d = fits ? trial : shifted[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], fits};
         end else begin
            {hi_d, lo_d} = {add_sum, lo_q[WIDTH-1:1]};
         end
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CNT_W'(WIDTH - 1)) begin
            last  = 1'b1;
            run_d = 1'b0;
         end
      end
   end

   // The top captures the post-iteration value on the same edge the counter reaches WIDTH
   assign res_lo = lo_d;
   assign res_hi = hi_d;

   // Iteration state register
   always_ff @(posedge clk) begin
      if (reset) begin
         run_q <= 1'b0;
         div_q <= 1'b0;
         cnt_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         b_q   <= '0;
      end else begin
         run_q <= run_d;
         div_q <= div_d;
         cnt_q <= cnt_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         b_q   <= b_d;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU with valid/ready handshake and registered results
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic [3:0]       operation,
   output logic             out_valid,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_hi,
   output logic             Zero
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] out_hi_q, out_hi_d;
   logic [WIDTH-1:0] single_res;
   logic             md_start;
   logic             md_is_div;
   logic             md_last;
   logic [WIDTH-1:0] md_lo;
   logic [WIDTH-1:0] md_hi;

   alu_muldiv_iter #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk    (clk),
      .reset  (reset),
      .start  (md_start),
      .is_div (md_is_div),
      .op_a   (in0),
      .op_b   (in1),
      .last   (md_last),
      .res_lo (md_lo),
      .res_hi (md_hi)
   );

   // Single-cycle operation mux; unknown opcodes yield zero
   always_comb begin
      single_res = '0;
      case (operation)
         ALU_AND: single_res = in0 & in1;
         ALU_OR:  single_res = in0 | in1;
         ALU_ADD: single_res = in0 + in1;
         ALU_SUB: single_res = in0 - in1;
         ALU_SLT: single_res = WIDTH'(in0 < in1);
         ALU_NOR: single_res = ~(in0 | in1);
         default: single_res = '0;
      endcase
   end

   // Next-state and result capture; outputs only change on entry to DONE
   always_comb begin
      state_d   = state_q;
      out_d     = out_q;
      out_hi_d  = out_hi_q;
      md_start  = 1'b0;
      md_is_div = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (operation == ALU_MULT) begin
                  md_start = 1'b1;
                  state_d  = ST_MUL;
               end else if (operation == ALU_DIVU) begin
                  if (in1 == '0) begin
                     out_d    = '1;
                     out_hi_d = in0;
                     state_d  = ST_DONE;
                  end else begin
                     md_start  = 1'b1;
                     md_is_div = 1'b1;
                     state_d   = ST_DIV;
                  end
               end else begin
                  out_d    = single_res;
                  out_hi_d = '0;
                  state_d  = ST_DONE;
               end
            end
         end
         ST_MUL, ST_DIV: begin
            if (md_last) begin
               out_d    = md_lo;
               out_hi_d = md_hi;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset aborts any operation in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         out_q    <= '0;
         out_hi_q <= '0;
      end else begin
         state_q  <= state_d;
         out_q    <= out_d;
         out_hi_q <= out_hi_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign out       = out_q;
   assign out_hi    = out_hi_q;
   assign Zero      = (out_q == '0);

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq: vector table, hand sequences, random vs model
module tb_alu_seq;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_MULT = 4'b1000;
   localparam logic [3:0] OP_DIVU = 4'b1001;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in0;
   logic [31:0] in1;
   logic [3:0]  operation;
   logic        out_valid;
   logic [31:0] out;
   logic [31:0] out_hi;
   logic        Zero;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] lo;
      logic [31:0] hi;
      int          lat;
   } vec_t;

   alu_seq #(
      .WIDTH (32)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in0       (in0),
      .in1       (in1),
      .operation (operation),
      .out_valid (out_valid),
      .out       (out),
      .out_hi    (out_hi),
      .Zero      (Zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: results from plain arithmetic on the operation's meaning
   task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] lo, output logic [31:0] hi, output int lat);
      logic [63:0] p;
      lo  = 32'd0;
      hi  = 32'd0;
      lat = 1;
      case (op)
         OP_AND: lo = a & b;
         OP_OR:  lo = a | b;
         OP_ADD: lo = a + b;
         OP_SUB: lo = a - b;
         OP_SLT: lo = (a < b) ? 32'd1 : 32'd0;
         OP_NOR: lo = ~(a | b);
         OP_MULT: begin
            p   = 64'(a) * 64'(b);
            lo  = p[31:0];
            hi  = p[63:32];
            lat = 33;
         end
         OP_DIVU: begin
            if (b == 32'd0) begin
               lo = 32'hFFFF_FFFF;
               hi = a;
            end else begin
               lo  = a / b;
               hi  = a % b;
               lat = 33;
            end
         end
         default: lo = 32'd0;
      endcase
   endtask

   // Issue one operation and wait (bounded) for its out_valid pulse
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] lo, output logic [31:0] hi, output logic z,
                         output int lat);
      logic busy_ok;
      @(negedge clk);
      chk("ready_before_issue", 64'(in_ready), 64'd1);
      operation = op;
      in0       = a;
      in1       = b;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat      = 0;
      busy_ok  = 1'b1;
      while (lat < 100) begin
         lat++;
         if (out_valid) break;
         if (in_ready) busy_ok = 1'b0;
         @(posedge clk);
         #1;
      end
      lo = out;
      hi = out_hi;
      z  = Zero;
      chk("in_ready_low_while_busy", 64'(busy_ok), 64'd1);
      @(posedge clk);
      #1;
      chk("out_valid_single_pulse", 64'({out_valid, in_ready}), 64'b01);
   endtask

   task automatic apply(input vec_t v);
      logic [31:0] lo;
      logic [31:0] hi;
      logic        z;
      int          lat;
      run_op(v.op, v.a, v.b, lo, hi, z, lat);
      chk({v.name, "_out"}, 64'(lo), 64'(v.lo));
      chk({v.name, "_out_hi"}, 64'(hi), 64'(v.hi));
      chk({v.name, "_zero"}, 64'(z), 64'(v.lo == 32'd0));
      chk({v.name, "_latency"}, 64'(lat), 64'(v.lat));
   endtask

   initial begin
      vec_t        vecs[$];
      vec_t        v;
      logic [3:0]  ops[9];
      logic [31:0] lo;
      logic [31:0] hi;
      logic        z;
      int          lat;
      int          pulses;
      logic [31:0] cap_lo;
      logic [31:0] cap_hi;

      vecs.push_back('{"add_wrap",   OP_ADD,  32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0,         1});
      vecs.push_back('{"slt_lt",     OP_SLT,  32'd3,         32'd5,         32'd1,         32'h0,         1});
      vecs.push_back('{"op_unknown", 4'b1111, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0,         32'h0,         1});
      vecs.push_back('{"mult_max",   OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 33});
      vecs.push_back('{"divu_100_7", OP_DIVU, 32'd100,       32'd7,         32'd14,        32'd2,         33});
      vecs.push_back('{"divu_by_0",  OP_DIVU, 32'd9,         32'd0,         32'hFFFF_FFFF, 32'd9,         1});
      vecs.push_back('{"and",        OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'h0,         1});
      vecs.push_back('{"or",         OP_OR,   32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 32'h0,         1});
      vecs.push_back('{"sub_wrap",   OP_SUB,  32'd0,         32'd1,         32'hFFFF_FFFF, 32'h0,         1});
      vecs.push_back('{"nor_zero",   OP_NOR,  32'h0,         32'h0,         32'hFFFF_FFFF, 32'h0,         1});
      vecs.push_back('{"slt_gt",     OP_SLT,  32'd5,         32'd3,         32'd0,         32'h0,         1});
      vecs.push_back('{"slt_eq",     OP_SLT,  32'h8000_0000, 32'h8000_0000, 32'd0,         32'h0,         1});
      vecs.push_back('{"mult_small", OP_MULT, 32'd6,         32'd7,         32'd42,        32'h0,         33});
      vecs.push_back('{"divu_small", OP_DIVU, 32'd5,         32'd9,         32'd0,         32'd5,         33});
      vecs.push_back('{"divu_by_1",  OP_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         33});
      vecs.push_back('{"add_clr_hi", OP_ADD,  32'd2,         32'd3,         32'd5,         32'h0,         1});

      reset     = 1'b1;
      in_valid  = 1'b0;
      in0       = '0;
      in1       = '0;
      operation = '0;

      // Reset held two cycles
      repeat (2) @(posedge clk);
      #1;
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      chk("reset_out", 64'(out), 64'd0);
      chk("reset_out_hi", 64'(out_hi), 64'd0);
      chk("reset_zero", 64'(Zero), 64'd1);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      reset = 1'b0;

      // Vector table
      foreach (vecs[i]) apply(vecs[i]);

      // in_valid pulsed with an AND while MULT is busy must be ignored
      @(negedge clk);
      operation = OP_MULT;
      in0       = 32'h1234_5678;
      in1       = 32'h9ABC_DEF0;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      pulses   = 0;
      cap_lo   = '0;
      cap_hi   = '0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         if (out_valid) begin
            pulses++;
            cap_lo = out;
            cap_hi = out_hi;
         end
         if (cyc == 5) begin
            operation = OP_AND;
            in0       = 32'hFFFF_FFFF;
            in1       = 32'h0000_00FF;
            in_valid  = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      model(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, lo, hi, lat);
      chk("busy_pulse_count", 64'(pulses), 64'd1);
      chk("busy_mult_out", 64'(cap_lo), 64'(lo));
      chk("busy_mult_out_hi", 64'(cap_hi), 64'(hi));
      chk("busy_final_out_kept", 64'(out), 64'(lo));

      // Reset during DIVU iteration aborts without out_valid
      @(negedge clk);
      operation = OP_DIVU;
      in0       = 32'hDEAD_BEEF;
      in1       = 32'h0000_1234;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      chk("abort_out", 64'(out), 64'd0);
      chk("abort_out_hi", 64'(out_hi), 64'd0);
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      reset  = 1'b0;
      pulses = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(posedge clk);
         #1;
         if (out_valid) pulses++;
      end
      chk("abort_no_out_valid", 64'(pulses), 64'd0);
      run_op(OP_ADD, 32'd2, 32'd3, lo, hi, z, lat);
      chk("after_abort_add", 64'(lo), 64'd5);

      // in_valid together with reset: reset wins, transaction dropped
      @(negedge clk);
      reset     = 1'b1;
      operation = OP_ADD;
      in0       = 32'd7;
      in1       = 32'd8;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      reset    = 1'b0;
      in_valid = 1'b0;
      pulses   = 0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         if (out_valid) pulses++;
         @(posedge clk);
         #1;
      end
      chk("reset_drop_no_valid", 64'(pulses), 64'd0);
      chk("reset_drop_out", 64'(out), 64'd0);
      chk("reset_drop_ready", 64'(in_ready), 64'd1);

      // Random operations against the reference model
      ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MULT, OP_DIVU, 4'b0011};
      for (int n = 0; n < 40; n++) begin
         v.name = "rand";
         v.op   = ops[$urandom_range(0, 8)];
         if (v.op == 4'b0011) v.op = 4'($urandom_range(0, 15));
         v.a = $urandom();
         case ($urandom_range(0, 5))
            0:       v.b = 32'd0;
            1:       v.b = 32'($urandom_range(1, 255));
            default: v.b = $urandom();
         endcase
         if ($urandom_range(0, 3) == 0) v.a = 32'($urandom_range(0, 1000));
         model(v.op, v.a, v.b, v.lo, v.hi, v.lat);
         apply(v);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
